// File: rtl/cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
// Shared types and constants for the cpu_6502 memory-side bus bridge.
//   bus_state_t  : bridge transaction phase (IDLE / REQ / RESP)
//   src_t        : which register currently drives the CPU read data
//   BUS_ERR_DATA : read data returned to the CPU when a grant wait times out
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } bus_state_t;

   typedef enum logic {
      SRC_FAST = 1'b0,
      SRC_EXT  = 1'b1
   } src_t;

   localparam logic [7:0] BUS_ERR_DATA = 8'hFF;

endpackage

// File: rtl/cpu_bus_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_if
// Bundles the CPU-side bus and the external-memory handshake of the bridge.
//   CPU side : cpu_ab, cpu_do, cpu_we (from CPU); cpu_di, cpu_rdy (to CPU)
//   Mem side : mem_req, mem_we, mem_addr, mem_wdata (to memory);
//              mem_gnt, mem_rvalid, mem_rdata (from memory)
// Modports: slave = the bridge, master = the CPU + external memory side.
//
// Handshake rules:
//   - CPU: the bridge takes the presented access on every rising edge where
//     cpu_rdy=1; the CPU then presents its next access. Read data for an
//     access appears on cpu_di in the next cycle with cpu_rdy=1.
//   - Memory: mem_req acts as valid and mem_gnt as ready; a request transfers
//     on an edge where both are 1, and mem_addr/mem_we/mem_wdata are stable
//     while mem_req=1. For reads, data transfers on the first later edge with
//     mem_rvalid=1; mem_rvalid in the grant cycle or while idle is ignored.
// ---------------------------------------------------------------------------
interface cpu_bus_if;

   logic [15:0] cpu_ab;
   logic [7:0]  cpu_do;
   logic        cpu_we;
   logic [7:0]  cpu_di;
   logic        cpu_rdy;

   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [7:0]  mem_rdata;

   modport slave (
      input  cpu_ab, cpu_do, cpu_we, mem_gnt, mem_rvalid, mem_rdata,
      output cpu_di, cpu_rdy, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_ab, cpu_do, cpu_we, mem_gnt, mem_rvalid, mem_rdata,
      input  cpu_di, cpu_rdy, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/fast_ram.sv
// ---------------------------------------------------------------------------
// fast_ram
// Synchronous single-port byte RAM with registered read data, no reset.
//   clk     : clock
//   we_i    : write enable (mem[addr_i] <= wdata_i)
//   re_i    : read enable  (rdata_o <= mem[addr_i]); rdata_o holds otherwise
//   addr_i  : byte address, AW bits
//   wdata_i : write data
//   rdata_o : registered read data
// ---------------------------------------------------------------------------
module fast_ram #(
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_bus_bridge.sv
// ---------------------------------------------------------------------------
// cpu_bus_bridge
// Memory-side stage for cpu_6502. Addresses below FAST_BYTES hit an internal
// zero-wait RAM; everything else goes to external memory over a req/gnt/rvalid
// handshake while cpu_rdy stalls the CPU. A grant wait longer than
// TIMEOUT_CYCLES aborts, returns BUS_ERR_DATA for reads and sets bus_err.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : cpu_bus_if.slave (CPU bus + external memory handshake)
//   bus_err   : sticky grant-timeout flag, cleared only by reset
//   dbg_state : current FSM state (bus_state_t encoding)
// ---------------------------------------------------------------------------
module cpu_bus_bridge
   import cpu_bus_pkg::*;
#(
   parameter int FAST_BYTES     = 512,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   cpu_bus_if.slave   bus,
   output logic       bus_err,
   output logic [1:0] dbg_state
);

   localparam int AW = $clog2(FAST_BYTES);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_REQ  = REQ;
   localparam logic [1:0] ST_RESP = RESP;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   addr_q, addr_d;
   logic          mem_we_q, mem_we_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    ext_q, ext_d;
   src_t          src_q, src_d;
   logic          err_q, err_d;

   logic          accept;
   logic          is_fast;
   logic          ram_we;
   logic          ram_re;
   logic [7:0]    ram_rdata;

   // rst_n is folded in so the CPU sees a stall while reset is held and
   // nothing (including a RAM write) is accepted during reset.
   assign accept  = (state_q == ST_IDLE) && rst_n;
   // FAST_BYTES is a power of two, so a hit is "all upper address bits zero".
   assign is_fast = (bus.cpu_ab[15:AW] == '0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      mem_we_d = mem_we_q;
      wdata_d  = wdata_q;
      ext_d    = ext_q;
      src_d    = src_q;
      err_d    = err_q;
      ram_we   = 1'b0;
      ram_re   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_fast) begin
                  ram_we = bus.cpu_we;
                  ram_re = !bus.cpu_we;
                  if (!bus.cpu_we) begin
                     src_d = SRC_FAST;
                  end
               end else begin
                  addr_d   = bus.cpu_ab;
                  mem_we_d = bus.cpu_we;
                  wdata_d  = bus.cpu_do;
                  cnt_d    = '0;
                  state_d  = ST_REQ;
               end
            end
         end

         ST_REQ: begin
            if (bus.mem_gnt) begin
               cnt_d   = '0;
               state_d = mem_we_q ? ST_IDLE : ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               // Grant never came: abandon the request. Reads get the error
               // byte so the CPU does not consume stale data.
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = ST_IDLE;
               if (!mem_we_q) begin
                  ext_d = BUS_ERR_DATA;
                  src_d = SRC_EXT;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RESP: begin
            if (bus.mem_rvalid) begin
               ext_d   = bus.mem_rdata;
               src_d   = SRC_EXT;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         mem_we_q <= 1'b0;
         wdata_q  <= '0;
         ext_q    <= '0;
         // Selecting the external register makes cpu_di read 00 out of reset
         // regardless of the (unreset) RAM contents.
         src_q    <= SRC_EXT;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         mem_we_q <= mem_we_d;
         wdata_q  <= wdata_d;
         ext_q    <= ext_d;
         src_q    <= src_d;
         err_q    <= err_d;
      end
   end

   fast_ram #(
      .DEPTH (FAST_BYTES),
      .AW    (AW)
   ) u_fast_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (bus.cpu_ab[AW-1:0]),
      .wdata_i (bus.cpu_do),
      .rdata_o (ram_rdata)
   );

   assign bus.cpu_rdy   = accept;
   assign bus.cpu_di    = (src_q == SRC_FAST) ? ram_rdata : ext_q;
   assign bus.mem_req   = (state_q == ST_REQ);
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus_err       = err_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_bridge
// Directed bench for cpu_bus_bridge. A transaction-level model (pending
// access, grant seen, cycles waited, byte array for the fast RAM) predicts
// cpu_rdy, mem_req, mem_* fields, cpu_di and bus_err; a negedge process
// compares them every cycle. Literal checks pin the expected values of each
// directed scenario. Inputs change on the falling edge only.
// ---------------------------------------------------------------------------
module tb_cpu_bus_bridge;

   localparam int FAST_BYTES     = 512;
   localparam int TIMEOUT_CYCLES = 16;

   // clock / reset
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bus_err;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   cpu_bus_if bus_if();

   cpu_bus_bridge #(
      .FAST_BYTES     (FAST_BYTES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_if),
      .bus_err   (bus_err),
      .dbg_state (dbg_state)
   );

   int total = 0;
   int bad   = 0;
   int rdy_low_cnt = 0;
   int req_hi_cnt  = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // behavioural model
   logic [7:0]  m_ram [FAST_BYTES];
   bit          m_pend    = 1'b0;
   bit          m_granted = 1'b0;
   int          m_age     = 0;
   logic [15:0] m_addr    = '0;
   logic        m_we      = 1'b0;
   logic [7:0]  m_wdata   = '0;
   logic [7:0]  m_di      = '0;
   logic        m_err     = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend    <= 1'b0;
         m_granted <= 1'b0;
         m_age     <= 0;
         m_addr    <= '0;
         m_we      <= 1'b0;
         m_wdata   <= '0;
         m_di      <= '0;
         m_err     <= 1'b0;
      end else if (!m_pend) begin
         if (int'(bus_if.cpu_ab) < FAST_BYTES) begin
            if (bus_if.cpu_we) m_ram[int'(bus_if.cpu_ab)] <= bus_if.cpu_do;
            else               m_di <= m_ram[int'(bus_if.cpu_ab)];
         end else begin
            m_pend    <= 1'b1;
            m_granted <= 1'b0;
            m_age     <= 0;
            m_addr    <= bus_if.cpu_ab;
            m_we      <= bus_if.cpu_we;
            m_wdata   <= bus_if.cpu_do;
         end
      end else if (!m_granted) begin
         if (bus_if.mem_gnt) begin
            if (m_we) m_pend <= 1'b0;
            else      m_granted <= 1'b1;
         end else if (m_age + 1 == TIMEOUT_CYCLES) begin
            m_pend <= 1'b0;
            m_err  <= 1'b1;
            if (!m_we) m_di <= 8'hFF;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (bus_if.mem_rvalid) begin
         m_di   <= bus_if.mem_rdata;
         m_pend <= 1'b0;
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      chk("cyc_rdy",   16'(bus_if.cpu_rdy),   16'(rst_n && !m_pend));
      chk("cyc_req",   16'(bus_if.mem_req),   16'(m_pend && !m_granted));
      chk("cyc_di",    16'(bus_if.cpu_di),    16'(m_di));
      chk("cyc_err",   16'(bus_err),          16'(m_err));
      chk("cyc_addr",  bus_if.mem_addr,       m_addr);
      chk("cyc_we",    16'(bus_if.mem_we),    16'(m_we));
      chk("cyc_wdata", 16'(bus_if.mem_wdata), 16'(m_wdata));
      if (rst_n && !bus_if.cpu_rdy) rdy_low_cnt++;
      if (bus_if.mem_req) req_hi_cnt++;
   end

   // driver tasks
   task automatic cpu_set(input logic [15:0] ab, input logic we, input logic [7:0] d);
      bus_if.cpu_ab = ab;
      bus_if.cpu_we = we;
      bus_if.cpu_do = d;
   endtask

   // Idle CPU traffic: a fast write to a scratch byte never read back, so
   // cpu_di is left untouched.
   task automatic cpu_idle();
      cpu_set(16'h0001, 1'b1, 8'h00);
   endtask

   task automatic wait_rdy(input int budget, input string name);
      int n = 0;
      while (!bus_if.cpu_rdy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 16'(bus_if.cpu_rdy), 16'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      cpu_idle();
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b0;
      bus_if.mem_rdata  = 8'h00;

      // 1. reset
      repeat (5) begin
         @(negedge clk);
         chk("rst_rdy", 16'(bus_if.cpu_rdy), 16'd0);
         chk("rst_req", 16'(bus_if.mem_req), 16'd0);
         chk("rst_di",  16'(bus_if.cpu_di),  16'h00);
         chk("rst_err", 16'(bus_err),        16'd0);
      end
      #2 rst_n = 1'b1;
      #1 chk("rel_rdy", 16'(bus_if.cpu_rdy), 16'd1);

      // 2. fast write then read-back, including top of fast region
      @(negedge clk);
      rdy_low_cnt = 0;
      req_hi_cnt  = 0;
      cpu_set(16'h0042, 1'b1, 8'h5A);
      @(negedge clk);
      cpu_set(16'h0042, 1'b0, 8'h00);
      @(negedge clk);
      chk("fast_rd_0042", 16'(bus_if.cpu_di), 16'h5A);
      cpu_set(16'h01FF, 1'b1, 8'hC3);
      @(negedge clk);
      cpu_set(16'h01FF, 1'b0, 8'h00);
      @(negedge clk);
      chk("fast_rd_01ff", 16'(bus_if.cpu_di), 16'hC3);
      cpu_idle();
      @(negedge clk);
      chk("fast_no_stall", 16'(rdy_low_cnt), 16'd0);
      chk("fast_no_req",   16'(req_hi_cnt),  16'd0);

      // 0x0200 is the first external address
      cpu_set(16'h0200, 1'b0, 8'h00);
      @(negedge clk);
      chk("ext_0200_req",  16'(bus_if.mem_req), 16'd1);
      chk("ext_0200_addr", bus_if.mem_addr,     16'h0200);
      cpu_idle();
      bus_if.mem_gnt = 1'b1;
      @(negedge clk);
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b1;
      bus_if.mem_rdata  = 8'h11;
      @(negedge clk);
      bus_if.mem_rvalid = 1'b0;
      chk("ext_0200_di",  16'(bus_if.cpu_di),  16'h11);
      chk("ext_0200_rdy", 16'(bus_if.cpu_rdy), 16'd1);

      // 3. external read, grant in 3rd REQ cycle, data in 2nd RESP cycle
      rdy_low_cnt = 0;
      req_hi_cnt  = 0;
      cpu_set(16'h1234, 1'b0, 8'h00);
      @(negedge clk);
      cpu_idle();
      chk("ext_rd_addr", bus_if.mem_addr,    16'h1234);
      chk("ext_rd_we",   16'(bus_if.mem_we), 16'd0);
      @(negedge clk);
      @(negedge clk);
      bus_if.mem_gnt = 1'b1;
      @(negedge clk);
      bus_if.mem_gnt = 1'b0;
      @(negedge clk);
      bus_if.mem_rvalid = 1'b1;
      bus_if.mem_rdata  = 8'hA7;
      @(negedge clk);
      bus_if.mem_rvalid = 1'b0;
      chk("ext_rd_di",     16'(bus_if.cpu_di),  16'hA7);
      chk("ext_rd_rdy",    16'(bus_if.cpu_rdy), 16'd1);
      chk("ext_rd_stall",  16'(rdy_low_cnt),    16'd5);
      chk("ext_rd_reqcyc", 16'(req_hi_cnt),     16'd3);

      // 4. external write with grant tied high
      rdy_low_cnt = 0;
      req_hi_cnt  = 0;
      bus_if.mem_gnt = 1'b1;
      cpu_set(16'h8000, 1'b1, 8'h33);
      @(negedge clk);
      cpu_idle();
      chk("ext_wr_req",   16'(bus_if.mem_req),   16'd1);
      chk("ext_wr_we",    16'(bus_if.mem_we),    16'd1);
      chk("ext_wr_wdata", 16'(bus_if.mem_wdata), 16'h33);
      chk("ext_wr_addr",  bus_if.mem_addr,       16'h8000);
      @(negedge clk);
      bus_if.mem_gnt = 1'b0;
      chk("ext_wr_rdy",    16'(bus_if.cpu_rdy), 16'd1);
      chk("ext_wr_stall",  16'(rdy_low_cnt),    16'd1);
      chk("ext_wr_reqcyc", 16'(req_hi_cnt),     16'd1);
      chk("ext_wr_di",     16'(bus_if.cpu_di),  16'hA7);

      // 5. grant timeout on a read, then bus_err stays set
      rdy_low_cnt = 0;
      req_hi_cnt  = 0;
      cpu_set(16'hFFFF, 1'b0, 8'h00);
      @(negedge clk);
      cpu_idle();
      wait_rdy(40, "to_done");
      chk("to_reqcyc", 16'(req_hi_cnt),    16'd16);
      chk("to_stall",  16'(rdy_low_cnt),   16'd16);
      chk("to_di",     16'(bus_if.cpu_di), 16'hFF);
      chk("to_err",    16'(bus_err),       16'd1);

      bus_if.mem_gnt = 1'b1;
      cpu_set(16'h0300, 1'b0, 8'h00);
      @(negedge clk);
      cpu_idle();
      @(negedge clk);
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b1;
      bus_if.mem_rdata  = 8'h5C;
      @(negedge clk);
      bus_if.mem_rvalid = 1'b0;
      chk("after_to_di",  16'(bus_if.cpu_di), 16'h5C);
      chk("after_to_err", 16'(bus_err),       16'd1);
      cpu_set(16'h0042, 1'b0, 8'h00);
      @(negedge clk);
      cpu_idle();
      chk("after_to_fast_di",  16'(bus_if.cpu_di), 16'h5A);
      chk("after_to_fast_err", 16'(bus_err),       16'd1);

      // 6. reset during RESP, stale rvalid afterwards
      cpu_set(16'h2000, 1'b0, 8'h00);
      @(negedge clk);
      cpu_idle();
      bus_if.mem_gnt = 1'b1;
      @(negedge clk);
      bus_if.mem_gnt = 1'b0;
      chk("resp_req", 16'(bus_if.mem_req), 16'd0);
      chk("resp_rdy", 16'(bus_if.cpu_rdy), 16'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_rdy",  16'(bus_if.cpu_rdy), 16'd0);
      chk("arst_req",  16'(bus_if.mem_req), 16'd0);
      chk("arst_di",   16'(bus_if.cpu_di),  16'h00);
      chk("arst_err",  16'(bus_err),        16'd0);
      chk("arst_addr", bus_if.mem_addr,     16'h0000);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      bus_if.mem_rvalid = 1'b1;
      bus_if.mem_rdata  = 8'h3C;
      @(negedge clk);
      @(negedge clk);
      bus_if.mem_rvalid = 1'b0;
      chk("stale_di",  16'(bus_if.cpu_di),  16'h00);
      chk("stale_rdy", 16'(bus_if.cpu_rdy), 16'd1);
      chk("stale_req", 16'(bus_if.mem_req), 16'd0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
Memory-side stage for cpu_6502. It drives the CPU's DI and RDY and serves the CPU's AB/DO/WE bus.
- Addresses below FAST_BYTES (zero page and stack) go to an internal zero-wait RAM.
- All other addresses go to a slower external memory through a req/gnt/rvalid handshake. CPU RDY is held low until that transaction completes.
- Replaces the ideal one-cycle memory model with a realistic, stall-capable bus front-end.

Parameters:
FAST_BYTES, 512, size of internal RAM; addresses 0..FAST_BYTES-1 hit it (power of two, ≤ 4096)
TIMEOUT_CYCLES, 16, maximum cycles in REQ before the grant wait is aborted (≥ 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
cpu_ab  in  16  CPU address
cpu_do  in  8  CPU write data
cpu_we  in  1  CPU write enable
cpu_di  out  8  read data to CPU (registered)
cpu_rdy  out  1  CPU ready; low stalls CPU
mem_req  out  1  external request valid
mem_we  out  1  external write
mem_addr  out  16  external address
mem_wdata  out  8  external write data
mem_gnt  in  1  external accepts request
mem_rvalid  in  1  external read data valid
mem_rdata  in  8  external read data
bus_err  out  1  sticky grant-timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - cpu_rdy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_di=8'h00, bus_err=0.
  - Timeout counter is 0.
  - Internal RAM contents are not reset.
- Outputs after reset release: cpu_rdy=(state==IDLE) and is registered-state-derived, so it is 1 in the first cycle after rst_n rises.
- An access is accepted only at a rising edge with state==IDLE. The CPU advances on that edge and presents its next address; it consumes the accepted access's read data in the next cycle in which cpu_rdy=1.
- Fast hit (cpu_ab < FAST_BYTES):
  - Write: RAM[ab] <= cpu_do.
  - Read: fast_q <= RAM[ab]; src select <= FAST.
  - State stays IDLE, so there is zero stall.
  - A write followed by a read of the same address in the next cycle returns the new value.
- External access, accepted in IDLE:
  - Latch addr, we and wdata into the mem_* registers; go to REQ.
  - REQ: mem_req=1 with stable fields. On an edge with mem_gnt=1, a write goes to IDLE and a read goes to RESP. mem_req deasserts the cycle after the grant.
  - RESP: mem_req=0. On an edge with mem_rvalid=1, ext_q <= mem_rdata, src select <= EXT, go to IDLE.
  - mem_rvalid is ignored outside RESP; the memory must not return data in its grant cycle.
- cpu_di = (src==FAST) ? fast_q : ext_q.
  - cpu_di is held during stalls.
  - After a write it holds its previous value (don't-care to the CPU).
- Stall length:
  - External write granted on the first REQ cycle: cpu_rdy low exactly 1 cycle.
  - External read: cpu_rdy low for (REQ cycles + RESP cycles).
- Timeout:
  - The counter increments each REQ cycle and clears on leaving REQ.
  - When the counter reaches TIMEOUT_CYCLES-1 without a grant:
    - drop mem_req;
    - for a read, ext_q <= 8'hFF and src <= EXT;
    - set bus_err=1 (sticky until reset);
    - go to IDLE.
  - RESP has no timeout: a granting memory must respond.
- Boundaries:
  - 0x01FF is fast, 0x0200 is external (default parameter).
  - 0xFFFF is external.
- Reset mid-transaction drops everything immediately. A stale mem_rvalid arriving after reset lands in IDLE and is ignored.

Decomposition:
- cpu_bus_pkg holds:
  - state enum bus_state_t {IDLE, REQ, RESP};
  - src enum {SRC_FAST, SRC_EXT};
  - constant BUS_ERR_DATA = 8'hFF.
- One sub-module, fast_ram: synchronous single-port byte RAM (we, addr, wdata, registered rdata), depth FAST_BYTES, no reset.

Test Plan:
1. rst_n=0 for 5 cycles, then release -> during reset cpu_rdy=0, mem_req=0, cpu_di=00, bus_err=0; cpu_rdy=1 in the first cycle after release.
2. Fast write 0x0042=0x5A, then read 0x0042 next cycle -> cpu_di=5A on the following cycle, cpu_rdy never low, mem_req never high. Repeat at 0x01FF (fast) and 0x0200 (external request issued).
3. External read 0x1234: mem_gnt high in the 3rd REQ cycle, mem_rvalid=A7 in the 2nd RESP cycle -> mem_addr=1234 and mem_we=0 stable while mem_req; cpu_rdy low 5 cycles; cpu_di=A7 when cpu_rdy returns.
4. External write 0x8000=0x33 with mem_gnt tied high -> mem_req, mem_we=1, mem_wdata=33 for 1 cycle; cpu_rdy low exactly 1 cycle.
5. External read with mem_gnt held low, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles then low; cpu_di=FF; bus_err=1 and stays 1 across later successful accesses.
6. rst_n pulsed low in RESP, then mem_rvalid=3C after release -> outputs return to reset values asynchronously; the late rvalid is ignored and cpu_di stays 00.
